// File: rtl/pwl_sequencer.sv
// Piecewise-linear batch sequencer: turns (start, slope, length) segments into per-batch start values for an interpolater.
// Latency: the first batch of a segment appears the cycle after it is accepted; the next segment follows with no gap.
// Backpressure: out_valid/out_ready stalls hold all outputs frozen; seg_ready only opens when the current segment is ending.
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   start, halt       - single-cycle run / abort commands (halt wins when both are high)
//   seg_*             - segment input: start value, per-sample slope (FRAC fraction bits), length in batches, final flag
//   out_*             - batch output: saturated start value, slope, final-batch marker
//   busy/done/underflow - running, one-cycle completion pulse, sticky starvation flag
module pwl_sequencer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int BATCH_SIZE   = 16,
    parameter int FRAC         = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      halt,
    input  logic [SAMPLE_WIDTH-1:0]   seg_x,
    input  logic [2*SAMPLE_WIDTH-1:0] seg_slope,
    input  logic [15:0]               seg_len,
    input  logic                      seg_last,
    input  logic                      seg_valid,
    output logic                      seg_ready,
    output logic [SAMPLE_WIDTH-1:0]   out_x,
    output logic [2*SAMPLE_WIDTH-1:0] out_slope,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic                      underflow
);

    localparam int LOG2B = $clog2(BATCH_SIZE);
    localparam int ACC_W = SAMPLE_WIDTH + FRAC + LOG2B + 2;
    localparam int XW    = ACC_W - FRAC;

    localparam logic signed [XW-1:0] X_MAX = {{(XW-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] X_MIN = {{(XW-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                          state_q, state_d;
    logic signed [ACC_W-1:0]         acc_q, acc_d;
    logic signed [2*SAMPLE_WIDTH-1:0] slope_q, slope_d;
    logic [15:0]                     rem_q, rem_d;
    logic                            last_q, last_d;
    logic                            cur_vld_q, cur_vld_d;
    logic                            done_q, done_d;
    logic                            underflow_q, underflow_d;
    // Set once a segment has been accepted in this run; underflow is only meaningful after that.
    logic                            seen_q, seen_d;

    logic                            batch_xfer;
    logic                            final_batch;
    logic                            finish;
    logic                            seg_xfer;
    logic signed [XW-1:0]            x_full;

    assign batch_xfer  = cur_vld_q & out_ready;
    assign final_batch = batch_xfer & (rem_q == 16'd1);
    assign finish      = final_batch & last_q;
    assign seg_xfer    = seg_valid & seg_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && !halt) state_d = S_RUN;
            S_RUN:   if (halt || finish) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (state_q == S_RUN);
        out_valid = cur_vld_q;
        out_last  = cur_vld_q & last_q & (rem_q == 16'd1);
        out_slope = slope_q;
        done      = done_q;
        underflow = underflow_q;
        // The final batch of the final segment closes the run, so no successor may slip in behind it.
        seg_ready = busy & (~cur_vld_q | (batch_xfer & (rem_q == 16'd1) & ~last_q));
        // The accumulator keeps full range; only the presented value is clamped.
        x_full = XW'(acc_q >>> FRAC);
        if (x_full > X_MAX) begin
            out_x = X_MAX[SAMPLE_WIDTH-1:0];
        end else if (x_full < X_MIN) begin
            out_x = X_MIN[SAMPLE_WIDTH-1:0];
        end else begin
            out_x = x_full[SAMPLE_WIDTH-1:0];
        end
    end

    // Segment datapath
    always_comb begin
        acc_d       = acc_q;
        slope_d     = slope_q;
        rem_d       = rem_q;
        last_d      = last_q;
        cur_vld_d   = cur_vld_q;
        done_d      = 1'b0;
        underflow_d = underflow_q;
        seen_d      = seen_q;

        if (state_q == S_IDLE) begin
            if (start && !halt) begin
                underflow_d = 1'b0;
                seen_d      = 1'b0;
            end
        end else if (halt) begin
            cur_vld_d = 1'b0;
        end else begin
            if (batch_xfer && rem_q > 16'd1) begin
                // One batch advances the start value by BATCH_SIZE samples of slope.
                acc_d = acc_q + (ACC_W'(slope_q) <<< LOG2B);
                rem_d = rem_q - 16'd1;
            end
            if (final_batch) begin
                cur_vld_d = 1'b0;
                done_d    = last_q;
            end
            if (seg_xfer) begin
                acc_d     = ACC_W'($signed(seg_x)) <<< FRAC;
                slope_d   = seg_slope;
                rem_d     = (seg_len == 16'd0) ? 16'd1 : seg_len;
                last_d    = seg_last;
                cur_vld_d = 1'b1;
                seen_d    = 1'b1;
            end
            if (!cur_vld_q && !seg_xfer && seen_q) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            slope_q     <= '0;
            rem_q       <= '0;
            last_q      <= 1'b0;
            cur_vld_q   <= 1'b0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
            seen_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            slope_q     <= slope_d;
            rem_q       <= rem_d;
            last_q      <= last_d;
            cur_vld_q   <= cur_vld_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
            seen_q      <= seen_d;
        end
    end

endmodule
